// File: rtl/access_control.sv
// access_control: password gate in front of the game datapath.
// The user keys a DIGITS-nibble code one nibble per button_pulse; each nibble
// is checked against a code held in an external synchronous ROM (address/q).
// A correct code grants access (green_led, ld1/ld2 pass through); a wrong
// code lights red_led and entry restarts from nibble 0.
// Optional build macro: ACCESS_LOCKOUT_EN -- after MAX_FAILS consecutive
// failed attempts the gate locks (red_led held) until rst.
module access_control #(
    parameter int DIGITS    = 4,
    parameter int BASE_ADDR = 0,
    parameter int ROM_LAT   = 2,
    parameter int MAX_FAILS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button_pulse,
    input  logic [3:0] toggle_switch,
    input  logic       ld1,
    input  logic       ld2,
    output logic       red_led,
    output logic       green_led,
    output logic       ld1_out,
    output logic       ld2_out,
    output logic [3:0] address,
    input  logic [3:0] q
);

    // Reject parameter sets the address/counter widths cannot represent.
    generate
        if (DIGITS < 1 || DIGITS > 16 || BASE_ADDR < 0 ||
            BASE_ADDR + DIGITS - 1 > 15 || ROM_LAT < 1 || MAX_FAILS < 1) begin : g_bad_param
            $error("access_control: illegal parameter combination");
        end
    endgenerate

    localparam int          CW       = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ROM_LAT - 1);
    localparam logic [3:0]  IDX_LAST = 4'(DIGITS - 1);
    localparam logic [3:0]  BASE     = 4'(BASE_ADDR);

    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        WAIT_PRESS = 2'd1,
        GRANT      = 2'd2,
        LOCKED     = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic          err;
    logic          granted;

    // Decoded events for the current cycle.
    logic press_acc;     // press taken in WAIT_PRESS
    logic mismatch;
    logic last;          // current nibble is the final one
    logic attempt_bad;   // any wrong nibble so far including this one
    logic attempt_ok;
    logic attempt_fail;
    logic lock_hit;      // this failure exhausts the retry budget

`ifdef ACCESS_LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAILS + 1);
    logic [FW-1:0] fails;
    logic [FW-1:0] fails_inc;
    assign fails_inc = fails + FW'(1);
    assign lock_hit  = attempt_fail && (fails_inc >= FW'(MAX_FAILS));

    // Consecutive-failure counter; a grant clears it.
    always_ff @(posedge clk) begin
        if (rst)
            fails <= '0;
        else if (attempt_ok)
            fails <= '0;
        else if (attempt_fail)
            fails <= fails_inc;
    end
`else
    assign lock_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= FETCH;
        else
            state <= state_n;
    end

    // Next-state logic: FETCH waits out ROM latency, WAIT_PRESS consumes one press.
    always_comb begin
        state_n = state;
        unique case (state)
            FETCH:
                if (cnt == CNT_LAST)
                    state_n = WAIT_PRESS;
            WAIT_PRESS:
                if (press_acc) begin
                    if (!last)
                        state_n = FETCH;
                    else if (attempt_ok)
                        state_n = GRANT;
                    else if (lock_hit)
                        state_n = LOCKED;
                    else
                        state_n = FETCH;
                end
            GRANT:   state_n = GRANT;
            LOCKED:  state_n = LOCKED;
            default: state_n = FETCH;
        endcase
    end

    // Output/decode logic: press evaluation, grant indicators and load gating.
    always_comb begin
        press_acc    = (state == WAIT_PRESS) && button_pulse;
        mismatch     = (toggle_switch != q);
        last         = (idx == IDX_LAST);
        attempt_bad  = err | mismatch;
        attempt_ok   = press_acc && last && !attempt_bad;
        attempt_fail = press_acc && last && attempt_bad;
        granted      = (state == GRANT);
        green_led    = granted;
        ld1_out      = ld1 & granted;
        ld2_out      = ld2 & granted;
    end

    // Entry datapath: latency counter, nibble index, sticky error, ROM address, red LED.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            err     <= 1'b0;
            address <= BASE;
            red_led <= 1'b0;
        end else begin
            cnt <= (state == FETCH && cnt != CNT_LAST) ? cnt + CW'(1) : '0;
            if (press_acc) begin
                // Any accepted press clears red; only a failing final press sets it.
                red_led <= attempt_fail;
                if (!last) begin
                    idx     <= idx + 4'd1;
                    err     <= attempt_bad;
                    address <= BASE + idx + 4'd1;
                end else if (attempt_bad) begin
                    idx     <= '0;
                    err     <= 1'b0;
                    address <= BASE;
                end
                // On success idx/address hold their final values for GRANT.
            end
        end
    end

endmodule

// File: tb/tb_access_control.sv
// Bench for access_control: directed scenarios plus randomized attempts,
// checked against a code-level model (entered nibbles vs ROM contents).
module tb_access_control;
    localparam int DIGITS    = 4;
    localparam int BASE_ADDR = 0;
    localparam int ROM_LAT   = 2;
    localparam int MAX_FAILS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button_pulse = 1'b0;
    logic [3:0] toggle_switch = 4'h0;
    logic       ld1 = 1'b0, ld2 = 1'b0;
    logic       red_led, green_led, ld1_out, ld2_out;
    logic [3:0] address;
    logic [3:0] q;
    logic [3:0] rom [16];

    access_control #(.DIGITS(DIGITS), .BASE_ADDR(BASE_ADDR), .ROM_LAT(ROM_LAT),
                     .MAX_FAILS(MAX_FAILS)) dut (
        .clk(clk), .rst(rst), .button_pulse(button_pulse), .toggle_switch(toggle_switch),
        .ld1(ld1), .ld2(ld2), .red_led(red_led), .green_led(green_led),
        .ld1_out(ld1_out), .ld2_out(ld2_out), .address(address), .q(q)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, one-cycle read.
    always @(posedge clk) q <= rom[address];

    int errors = 0;
    int checks = 0;

    // Reference model: nibbles entered in the current attempt.
    logic [3:0] entered[$];
    bit m_green, m_red, m_locked;
    int m_fails;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit code_ok();
        for (int i = 0; i < DIGITS; i++)
            if (entered[i] !== rom[BASE_ADDR + i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        entered.delete();
        m_green = 0; m_red = 0; m_locked = 0; m_fails = 0;
    endtask

    task automatic model_press(input logic [3:0] n);
        if (m_green || m_locked) return;
        entered.push_back(n);
        m_red = 0;
        if (entered.size() == DIGITS) begin
            if (code_ok()) begin
                m_green = 1; m_fails = 0;
            end else begin
                m_red = 1; m_fails++;
`ifdef ACCESS_LOCKOUT_EN
                if (m_fails >= MAX_FAILS) m_locked = 1;
`endif
            end
            entered.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_clear();
    endtask

    // One press after a gap long enough for the ROM fetch, then check outputs.
    task automatic press(input logic [3:0] n);
        repeat (ROM_LAT + 1 + $urandom_range(0, 2)) @(negedge clk);
        toggle_switch = n;
        button_pulse  = 1'b1;
        ld1 = 1'($urandom);
        ld2 = 1'($urandom);
        @(negedge clk);
        button_pulse  = 1'b0;
        toggle_switch = 4'($urandom);
        model_press(n);
        check("red", 32'(red_led), 32'(m_red));
        check("green", 32'(green_led), 32'(m_green));
        check("ld1_out", 32'(ld1_out), 32'(ld1 & m_green));
        check("ld2_out", 32'(ld2_out), 32'(ld2 & m_green));
        check("led_excl", 32'(red_led & green_led), 32'd0);
    endtask

    task automatic enter(input logic [15:0] code);
        for (int i = DIGITS - 1; i >= 0; i--) press(code[i*4 +: 4]);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'h0;
        rom[BASE_ADDR+0] = 4'hD; rom[BASE_ADDR+1] = 4'h7;
        rom[BASE_ADDR+2] = 4'h2; rom[BASE_ADDR+3] = 4'h9;

        // Reset state, with loads already requested.
        ld1 = 1'b1; ld2 = 1'b1;
        do_reset();
        check("rst_addr", 32'(address), 32'(BASE_ADDR));
        check("rst_red", 32'(red_led), 32'd0);
        check("rst_green", 32'(green_led), 32'd0);
        check("rst_ld1", 32'(ld1_out), 32'd0);
        check("rst_ld2", 32'(ld2_out), 32'd0);

        // Correct code grants; gating is combinational once granted.
        enter(16'hD729);
        check("grant_green", 32'(green_led), 32'd1);
        ld1 = 1'b1; ld2 = 1'b0; #1;
        check("grant_ld1_same_cycle", 32'(ld1_out), 32'd1);
        check("grant_ld2_low", 32'(ld2_out), 32'd0);
        ld1 = 1'b0; #1;
        check("grant_ld1_drop", 32'(ld1_out), 32'd0);
        // Presses in GRANT are ignored and the address holds.
        press(4'h0);
        check("grant_addr_hold", 32'(address), 32'(BASE_ADDR + DIGITS - 1));

        // Wrong code, then retry.
        do_reset();
        enter(16'hD728);
        check("wrong_addr_back", 32'(address), 32'(BASE_ADDR));
        enter(16'hD729);

        // Button held high from reset: one press per fetch pass.
        @(negedge clk); rst = 1'b1; toggle_switch = 4'hF;
        @(negedge clk); rst = 1'b0; button_pulse = 1'b1;
        model_clear();
        for (int t = 0; t < DIGITS * (ROM_LAT + 1); t++) begin
            if (t > 0) @(negedge clk);
            check("held_addr", 32'(address), 32'(BASE_ADDR + t / (ROM_LAT + 1)));
            check("held_red", 32'(red_led), 32'd0);
        end
        @(negedge clk); button_pulse = 1'b0;
        for (int i = 0; i < DIGITS; i++) model_press(4'hF);
        check("held_red_end", 32'(red_led), 32'(m_red));
        check("held_addr_end", 32'(address), 32'(BASE_ADDR));

        // Reset mid-entry discards progress.
        do_reset();
        press(4'hD); press(4'h7);
        check("mid_addr", 32'(address), 32'(BASE_ADDR + 2));
        do_reset();
        check("mid_rst_addr", 32'(address), 32'(BASE_ADDR));
        check("mid_rst_red", 32'(red_led), 32'd0);
        check("mid_rst_green", 32'(green_led), 32'd0);
        enter(16'hD729);

`ifdef ACCESS_LOCKOUT_EN
        // Lockout after MAX_FAILS wrong codes; rst recovers.
        do_reset();
        for (int k = 0; k < MAX_FAILS; k++) enter(16'h1111);
        enter(16'hD729);
        check("lock_green", 32'(green_led), 32'd0);
        check("lock_red", 32'(red_led), 32'd1);
        do_reset();
        enter(16'hD729);
        check("lock_recover", 32'(green_led), 32'd1);
`endif

        // Randomized rounds: random ROM code, mix of right and wrong attempts.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) rom[i] = 4'($urandom);
            do_reset();
            for (int a = 0; a < 4; a++) begin
                int bad_pos;
                bad_pos = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, DIGITS - 1));
                for (int d = 0; d < DIGITS; d++) begin
                    logic [3:0] n;
                    n = rom[BASE_ADDR + d];
                    if (d == bad_pos) n = n ^ 4'($urandom_range(1, 15));
                    press(n);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/access_control.md
Name: access_control

Overview:
- Password gate in front of the game datapath.
- User enters a DIGITS-nibble code on toggle_switch, one nibble per button_pulse. Each nibble is compared with a stored code read from an external synchronous ROM through address/q.
- Correct code: green_led lights and the load strobes ld1/ld2 pass through to the game. Wrong code: red_led lights and the user retries.

Parameters:
- DIGITS, 4, number of nibbles in the code (1..16).
- BASE_ADDR, 0, ROM address of code nibble 0; BASE_ADDR+DIGITS-1 must be ≤ 15.
- ROM_LAT, 2, cycles the FSM waits after changing address before q is trusted (≥1).
- MAX_FAILS, 3, consecutive failed attempts before lockout; used only with ACCESS_LOCKOUT_EN.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- button_pulse  in  1  one-cycle "enter" strobe from upstream debouncer; every high cycle counts as one press.
- toggle_switch  in  4  nibble entered by the user.
- ld1  in  1  game load strobe 1.
- ld2  in  1  game load strobe 2.
- red_led  out  1  access denied / locked indicator.
- green_led  out  1  access granted indicator.
- ld1_out  out  1  ld1 gated by grant.
- ld2_out  out  1  ld2 gated by grant.
- address  out  4  ROM address, registered.
- q  in  4  ROM data for address.

Behaviour:
- Reset values: state=FETCH, idx=0, err=0, fails=0, address=BASE_ADDR, red_led=0, green_led=0, granted=0, so ld1_out=ld2_out=0.
- FETCH:
  - address = BASE_ADDR+idx.
  - Counts ROM_LAT cycles, then moves to WAIT_PRESS.
  - button_pulse is ignored (dropped, not queued).
- WAIT_PRESS: on button_pulse, mismatch = (toggle_switch != q).
  - If idx < DIGITS-1: err <= err|mismatch, idx++, go FETCH.
  - If idx == DIGITS-1: final = err|mismatch.
    - final=0: go GRANT; green_led<=1, red_led<=0, granted<=1, fails<=0.
    - final=1: red_led<=1, fails++, idx<=0, err<=0, go FETCH.
  - red_led is cleared by the first accepted press of the next attempt.
- GRANT:
  - Terminal until rst.
  - green_led=1; button_pulse ignored; address holds last value.
- Gating:
  - ld1_out = ld1 & granted and ld2_out = ld2 & granted, combinational, zero latency.
  - Before grant, ld1/ld2 are ignored whatever their value.
- Comparison is a full 4-bit equality. Any single wrong nibble fails the whole attempt, but entry always continues to DIGITS presses (no early abort, no hint to the user).
- The button press is sampled on the same edge as toggle_switch and q; values changing on that edge use the pre-edge value.
- rst mid-entry: all progress discarded, entry restarts at nibble 0, LEDs off.
- green_led and red_led are never both 1.

Optional Feature:
- Macro ACCESS_LOCKOUT_EN.
- Defined:
  - When fails reaches MAX_FAILS, go LOCKED: red_led=1, green_led=0, ld outputs 0.
  - All presses are ignored; only rst exits.
  - A successful attempt clears fails.
- Undefined:
  - Unlimited retries; the fails counter is not implemented and MAX_FAILS is unused.

Test Plan:
- Correct code: ROM[0..3]=D,7,2,9; after reset, wait ≥ROM_LAT+1 cycles before each press; enter D,7,2,9 → green_led=1 one cycle after 4th press, red_led=0; ld1=1 → ld1_out=1 same cycle.
- Wrong code: enter D,7,2,8 → red_led=1, green_led=0, ld1_out=0 with ld1=1. Address returns to 0; retry D,7,2,9 → red_led clears on first press, then green_led=1.
- Press during FETCH: button_pulse held high continuously after reset → exactly one press accepted per FETCH/WAIT_PRESS pass. Address steps 0,1,2,3, each held ROM_LAT+1 cycles; all-F entry against ROM D,7,2,9 → red_led=1.
- Reset mid-entry: enter D,7, assert rst one cycle → address=0, LEDs 0. Full D,7,2,9 still grants.
- Pre-grant gating: ld1=ld2=1 from reset → ld1_out=ld2_out=0 until grant, then both 1.
- Lockout (ACCESS_LOCKOUT_EN): three wrong codes → red_led latched. A fourth correct code → no green_led. rst → fresh entry and grant works.
